// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter and
// the store unit.
//
// Contents:
//   DMEM_ADDR_W / DMEM_DATA_W : default widths of the data-memory port
//   dmem_state_t              : arbiter sequencing states
//   F3_*                      : RV32I load/store width codes
//   dmem_req_t                : one latched memory request
//   f3_is_illegal()           : width codes that have no memory meaning
package dmem_pkg;

  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // The request register is sized by the package widths, so instances of
  // the arbiter keep their width parameters equal to these.
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [2:0]             funct3;
  } dmem_req_t;

  // 011, 110 and 111 are not load/store widths; they are answered with an
  // error response just like a misaligned access.
  function automatic logic f3_is_illegal(input logic [2:0] f3);
    return !((f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU));
  endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// dmem_align_chk: combinational alignment check for a data-memory access.
// Shared between the arbiter and the store unit.
//
// Ports:
//   funct3     in  3 : RV32I width code of the access
//   addr_lo    in  2 : two low bits of the byte address
//   misaligned out 1 : halfword on an odd address, or word not on a
//                      4-byte boundary
module dmem_align_chk
  import dmem_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  // Only the size bits matter: signed and unsigned loads of the same width
  // share the same alignment rule.
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      F3_LH[1:0]: misaligned = addr_lo[0];
      F3_LW[1:0]: misaligned = (addr_lo != 2'b00);
      default:    misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of datamemory.
// Port 0 is the core load/store path, port 1 the DMA/debug loader.
//
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   reqN, weN, addrN, wdataN,
//   funct3_N                     : request of port N, held until readyN
//   readyN                       : request of port N accepted this cycle
//   rvalidN, rdataN, errN        : one-cycle registered completion of port N
//   mem_read, mem_write,
//   mem_addr, mem_wdata,
//   mem_funct3                   : registered controls to datamemory
//   mem_rdata                    : read data from datamemory
//
// Every accepted request spends one cycle in ACCESS and one in RESP. A new
// request may be accepted in RESP, so back-to-back traffic completes one
// transaction every two cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  req0,
  input  logic                  we0,
  input  logic [DM_ADDRESS-1:0] addr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [2:0]            funct3_0,
  output logic                  ready0,
  output logic                  rvalid0,
  output logic [DATA_W-1:0]     rdata0,
  output logic                  err0,

  input  logic                  req1,
  input  logic                  we1,
  input  logic [DM_ADDRESS-1:0] addr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [2:0]            funct3_1,
  output logic                  ready1,
  output logic                  rvalid1,
  output logic [DATA_W-1:0]     rdata1,
  output logic                  err1,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  dmem_state_t state;
  dmem_state_t state_next;

  logic      can_accept;
  logic      accept;
  logic      grant;
  logic      owner;
  logic      last_owner;
  dmem_req_t sel_req;
  dmem_req_t req_q;
  logic      sel_misaligned;
  logic      sel_bad;
  logic      bad_q;

  // Round-robin: on a tie the port that did not win last time is served.
  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_owner;
    end else begin
      grant = req1;
    end
  end

  always_comb begin
    sel_req = '0;
    if (grant) begin
      sel_req.we     = we1;
      sel_req.addr   = addr1;
      sel_req.wdata  = wdata1;
      sel_req.funct3 = funct3_1;
    end else begin
      sel_req.we     = we0;
      sel_req.addr   = addr0;
      sel_req.wdata  = wdata0;
      sel_req.funct3 = funct3_0;
    end
  end

  dmem_align_chk u_align_chk (
    .funct3     (sel_req.funct3),
    .addr_lo    (sel_req.addr[1:0]),
    .misaligned (sel_misaligned)
  );

  assign sel_bad    = sel_misaligned | f3_is_illegal(sel_req.funct3);
  assign can_accept = (state == IDLE) || (state == RESP);
  assign accept     = can_accept && (req0 || req1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ready is the only combinational output; it is the accept decision
  // steered to the granted port.
  always_comb begin
    state_next = state;
    ready0     = 1'b0;
    ready1     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = RESP;
      end
      RESP: begin
        if (accept) begin
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (accept) begin
      ready0 = ~grant;
      ready1 = grant;
    end
  end

  // The request is latched at acceptance, so the memory controls are
  // already registered when ACCESS starts. A bad access keeps both strobes
  // low and never reaches memory.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q      <= '0;
      bad_q      <= 1'b0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if (accept) begin
        req_q      <= sel_req;
        bad_q      <= sel_bad;
        owner      <= grant;
        last_owner <= grant;
        mem_read   <= ~sel_req.we & ~sel_bad;
        mem_write  <= sel_req.we & ~sel_bad;
      end
    end
  end

  assign mem_addr   = req_q.addr;
  assign mem_wdata  = req_q.wdata;
  assign mem_funct3 = req_q.funct3;

  // datamemory settles rd on the falling edge inside ACCESS, so the
  // response is captured on the rising edge that ends ACCESS. Only the
  // owner's response registers load; the other port stays at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rvalid0 <= 1'b0;
      rdata0  <= '0;
      err0    <= 1'b0;
      rvalid1 <= 1'b0;
      rdata1  <= '0;
      err1    <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rdata0  <= '0;
      err0    <= 1'b0;
      rvalid1 <= 1'b0;
      rdata1  <= '0;
      err1    <= 1'b0;
      if (state == ACCESS) begin
        if (owner) begin
          rvalid1 <= 1'b1;
          err1    <= bad_q;
          rdata1  <= (bad_q || req_q.we) ? '0 : mem_rdata;
        end else begin
          rvalid0 <= 1'b1;
          err0    <= bad_q;
          rdata0  <= (bad_q || req_q.we) ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule
